// File: rtl/cpu_bus_bridge_pkg.sv
// cpu_bus_pkg: shared types and address-map constants for cpu_bus_bridge.
//   bus_state_t   - bridge FSM states
//   bus_request_t - request latched at acceptance (address, data, is_write)
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAM_WAIT,
    EXT_STROBE,
    RESPOND,
    COOLDOWN
  } bus_state_t;

  typedef struct packed {
    logic [15:0] address;
    logic [7:0]  data;
    logic        is_write;
  } bus_request_t;

  localparam logic [15:0] RAM_REGION_END = 16'h1FFF;
  localparam logic [15:0] OPEN_BUS_START = 16'h4020;
  localparam logic [15:0] OPEN_BUS_END   = 16'h5FFF;

endpackage

// File: rtl/cpu_bus_bridge_if.sv
// cpu_bus_bridge_if: groups the cpu request/response and external bus pins.
//   slave  modport - seen by the bridge (cpu and ext_data_i are inputs)
//   master modport - seen by the cpu/board side
interface cpu_bus_bridge_if;
  logic [15:0] cpu_address_i;
  logic        cpu_address_valid_i;
  logic [7:0]  cpu_data_i;
  logic        cpu_data_valid_i;
  logic [7:0]  cpu_data_o;
  logic        cpu_data_valid_o;
  logic [15:0] ext_address_o;
  logic [7:0]  ext_data_o;
  logic        ext_data_oe_o;
  logic [7:0]  ext_data_i;
  logic        ext_read_n_o;
  logic        ext_write_n_o;

  modport slave (
    input  cpu_address_i, cpu_address_valid_i, cpu_data_i, cpu_data_valid_i, ext_data_i,
    output cpu_data_o, cpu_data_valid_o, ext_address_o, ext_data_o, ext_data_oe_o,
           ext_read_n_o, ext_write_n_o
  );

  modport master (
    output cpu_address_i, cpu_address_valid_i, cpu_data_i, cpu_data_valid_i, ext_data_i,
    input  cpu_data_o, cpu_data_valid_o, ext_address_o, ext_data_o, ext_data_oe_o,
           ext_read_n_o, ext_write_n_o
  );
endinterface

// File: rtl/cpu_bus_bridge_work_ram.sv
// work_ram: single-port 2^RAM_ADDR_BITS x 8 synchronous RAM, no reset.
//   clock_i, we_i, addr_i, wdata_i in; rdata_o out, one cycle after addr_i.
//   A read in the same cycle as a write returns the old contents.
module work_ram #(
  parameter int unsigned RAM_ADDR_BITS = 11
) (
  input  logic                     clock_i,
  input  logic                     we_i,
  input  logic [RAM_ADDR_BITS-1:0] addr_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o
);
  logic [7:0] mem [2**RAM_ADDR_BITS];
  logic [7:0] rdata_d, rdata_q;

  always_comb rdata_d = mem[addr_i];

  always_ff @(posedge clock_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: decodes cpu accesses to the mirrored work RAM ($0000-$1FFF)
// or a strobed external parallel bus (all other addresses).
//   clock_i   - system clock
//   reset_n_i - synchronous active-low reset
//   bus       - cpu_bus_bridge_if.slave (cpu request/response, external bus)
// Optional: `define CPU_BUS_OPEN_BUS_EN makes reads in $4020-$5FFF return the
// last transferred byte without an external cycle.
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter int unsigned EXT_WAIT_CYCLES = 3,
  parameter int unsigned RAM_ADDR_BITS   = 11
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  cpu_bus_bridge_if.slave  bus
);
  bus_state_t   state_d, state_q;
  bus_request_t req_d, req_q;
  logic [7:0]   cpu_data_d, cpu_data_q;
  logic         cpu_data_valid_d, cpu_data_valid_q;
  logic [15:0]  ext_address_d, ext_address_q;
  logic [7:0]   ext_data_d, ext_data_q;
  logic         ext_data_oe_d, ext_data_oe_q;
  logic         ext_read_n_d, ext_read_n_q;
  logic         ext_write_n_d, ext_write_n_q;
  logic [3:0]   wait_cnt_d, wait_cnt_q;
  logic         ram_we_req, ram_we;
  logic [7:0]   ram_rdata;
`ifdef CPU_BUS_OPEN_BUS_EN
  logic [7:0]   open_bus_d, open_bus_q;
`endif

  // The RAM access is issued from the live cpu inputs in the acceptance cycle.
  assign ram_we = ram_we_req && reset_n_i;

  work_ram #(.RAM_ADDR_BITS(RAM_ADDR_BITS)) u_work_ram (
    .clock_i (clock_i),
    .we_i    (ram_we),
    .addr_i  (bus.cpu_address_i[RAM_ADDR_BITS-1:0]),
    .wdata_i (bus.cpu_data_i),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    cpu_data_d       = cpu_data_q;
    cpu_data_valid_d = 1'b0;
    ext_address_d    = ext_address_q;
    ext_data_d       = ext_data_q;
    ext_data_oe_d    = ext_data_oe_q;
    ext_read_n_d     = ext_read_n_q;
    ext_write_n_d    = ext_write_n_q;
    wait_cnt_d       = wait_cnt_q;
    ram_we_req       = 1'b0;
`ifdef CPU_BUS_OPEN_BUS_EN
    open_bus_d       = open_bus_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_address_valid_i) begin
          req_d.address  = bus.cpu_address_i;
          req_d.data     = bus.cpu_data_i;
          req_d.is_write = bus.cpu_data_valid_i;
          if (bus.cpu_address_i <= RAM_REGION_END) begin
            ram_we_req = bus.cpu_data_valid_i;
`ifdef CPU_BUS_OPEN_BUS_EN
            if (bus.cpu_data_valid_i) open_bus_d = bus.cpu_data_i;
`endif
            state_d = RAM_WAIT;
`ifdef CPU_BUS_OPEN_BUS_EN
          end else if (!bus.cpu_data_valid_i && bus.cpu_address_i >= OPEN_BUS_START &&
                       bus.cpu_address_i <= OPEN_BUS_END) begin
            cpu_data_d       = open_bus_q;
            cpu_data_valid_d = 1'b1;
            state_d          = RESPOND;
`endif
          end else begin
            ext_address_d = bus.cpu_address_i;
            if (bus.cpu_data_valid_i) begin
              ext_data_d    = bus.cpu_data_i;
              ext_data_oe_d = 1'b1;
              ext_write_n_d = 1'b0;
            end else begin
              ext_read_n_d = 1'b0;
            end
            wait_cnt_d = 4'(EXT_WAIT_CYCLES);
            state_d    = EXT_STROBE;
          end
        end
      end
      RAM_WAIT: begin
        if (!req_q.is_write) begin
          cpu_data_d = ram_rdata;
`ifdef CPU_BUS_OPEN_BUS_EN
          open_bus_d = ram_rdata;
`endif
        end
        cpu_data_valid_d = 1'b1;
        state_d          = RESPOND;
      end
      EXT_STROBE: begin
        // Pins stay tied to the latched request for the whole strobe.
        ext_address_d = req_q.address;
        if (req_q.is_write) ext_data_d = req_q.data;
        if (wait_cnt_q == 4'd0) begin
          ext_read_n_d  = 1'b1;
          ext_write_n_d = 1'b1;
          ext_data_oe_d = 1'b0;
          if (!req_q.is_write) begin
            cpu_data_d = bus.ext_data_i;
`ifdef CPU_BUS_OPEN_BUS_EN
            open_bus_d = bus.ext_data_i;
          end else begin
            open_bus_d = req_q.data;
`endif
          end
          cpu_data_valid_d = 1'b1;
          state_d          = RESPOND;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESPOND:  state_d = COOLDOWN;
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q          <= IDLE;
      req_q            <= '0;
      cpu_data_q       <= '0;
      cpu_data_valid_q <= 1'b0;
      ext_address_q    <= '0;
      ext_data_q       <= '0;
      ext_data_oe_q    <= 1'b0;
      ext_read_n_q     <= 1'b1;
      ext_write_n_q    <= 1'b1;
      wait_cnt_q       <= '0;
`ifdef CPU_BUS_OPEN_BUS_EN
      open_bus_q       <= '0;
`endif
    end else begin
      state_q          <= state_d;
      req_q            <= req_d;
      cpu_data_q       <= cpu_data_d;
      cpu_data_valid_q <= cpu_data_valid_d;
      ext_address_q    <= ext_address_d;
      ext_data_q       <= ext_data_d;
      ext_data_oe_q    <= ext_data_oe_d;
      ext_read_n_q     <= ext_read_n_d;
      ext_write_n_q    <= ext_write_n_d;
      wait_cnt_q       <= wait_cnt_d;
`ifdef CPU_BUS_OPEN_BUS_EN
      open_bus_q       <= open_bus_d;
`endif
    end
  end

  assign bus.cpu_data_o       = cpu_data_q;
  assign bus.cpu_data_valid_o = cpu_data_valid_q;
  assign bus.ext_address_o    = ext_address_q;
  assign bus.ext_data_o       = ext_data_q;
  assign bus.ext_data_oe_o    = ext_data_oe_q;
  assign bus.ext_read_n_o     = ext_read_n_q;
  assign bus.ext_write_n_o    = ext_write_n_q;
endmodule

// File: tb/tb_cpu_bus_bridge.sv
// tb_cpu_bus_bridge: directed test of cpu_bus_bridge with EXT_WAIT_CYCLES=3.
// Covers RAM mirroring, external read/write strobes, held requests, mid-access
// reset and (with CPU_BUS_OPEN_BUS_EN) the open-bus read range.
module tb_cpu_bus_bridge;
  logic clock_i = 1'b0;
  logic reset_n_i;
  always #5 clock_i = ~clock_i;

  cpu_bus_bridge_if bus();

  cpu_bus_bridge #(.EXT_WAIT_CYCLES(3), .RAM_ADDR_BITS(11)) dut (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  // Per-cycle activity counters, sampled away from the active edge.
  int pulse_cnt = 0, rd_low_cnt = 0, wr_low_cnt = 0, oe_cnt = 0;
  always @(negedge clock_i) begin
    if (bus.cpu_data_valid_o) pulse_cnt++;
    if (!bus.ext_read_n_o)    rd_low_cnt++;
    if (!bus.ext_write_n_o)   wr_low_cnt++;
    if (bus.ext_data_oe_o)    oe_cnt++;
  end

  int tests_run = 0, tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         lat;
  logic [7:0] rdata;
  int         d_pulse, d_rd, d_wr, d_oe;

  // One request held until its completion pulse; lat = pulse cycle - accept cycle.
  task automatic access(input logic [15:0] a, input logic [7:0] d, input logic w);
    int n, p0, r0, w0, o0;
    bit seen;
    p0 = pulse_cnt; r0 = rd_low_cnt; w0 = wr_low_cnt; o0 = oe_cnt;
    seen = 1'b0; lat = -1; rdata = 8'h00;
    @(posedge clock_i); #1;
    bus.cpu_address_i = a; bus.cpu_data_i = d;
    bus.cpu_data_valid_i = w; bus.cpu_address_valid_i = 1'b1;
    n = cyc;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clock_i);
      if (bus.cpu_data_valid_o) begin
        seen = 1'b1; lat = cyc - n; rdata = bus.cpu_data_o;
      end
    end
    @(posedge clock_i); #1;
    bus.cpu_address_valid_i = 1'b0; bus.cpu_data_valid_i = 1'b0;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    d_pulse = pulse_cnt - p0; d_rd = rd_low_cnt - r0;
    d_wr = wr_low_cnt - w0;   d_oe = oe_cnt - o0;
  endtask

  initial begin
    int p0;
    reset_n_i = 1'b0;
    bus.cpu_address_i = '0; bus.cpu_address_valid_i = 1'b0;
    bus.cpu_data_i = '0;    bus.cpu_data_valid_i = 1'b0;
    bus.ext_data_i = '0;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    check("rst_data",   32'(bus.cpu_data_o), 32'h0);
    check("rst_valid",  32'(bus.cpu_data_valid_o), 32'h0);
    check("rst_eaddr",  32'(bus.ext_address_o), 32'h0);
    check("rst_edata",  32'(bus.ext_data_o), 32'h0);
    check("rst_oe",     32'(bus.ext_data_oe_o), 32'h0);
    check("rst_rd_n",   32'(bus.ext_read_n_o), 32'h1);
    check("rst_wr_n",   32'(bus.ext_write_n_o), 32'h1);
    @(posedge clock_i); #1; reset_n_i = 1'b1;

    // RAM write then mirrored read.
    access(16'h0005, 8'hA5, 1'b1);
    check("ramw_lat",    32'(lat), 32'd2);
    check("ramw_pulses", 32'(d_pulse), 32'd1);
    check("ramw_nostrb", 32'(d_rd + d_wr), 32'd0);
    access(16'h0805, 8'h00, 1'b0);
    check("ramr_lat",    32'(lat), 32'd2);
    check("ramr_data",   32'(rdata), 32'hA5);
    check("ramr_pulses", 32'(d_pulse), 32'd1);
    // Top of the RAM region, read back through the offset $07FF.
    access(16'h1FFF, 8'h11, 1'b1);
    check("top_w_lat",   32'(lat), 32'd2);
    access(16'h07FF, 8'h00, 1'b0);
    check("top_r_data",  32'(rdata), 32'h11);
    check("top_eaddr",   32'(bus.ext_address_o), 32'h0);

    // External read at the first non-RAM address.
    bus.ext_data_i = 8'h3C;
    access(16'h2000, 8'h00, 1'b0);
    check("extr_lat",    32'(lat), 32'd5);
    check("extr_data",   32'(rdata), 32'h3C);
    check("extr_rd_low", 32'(d_rd), 32'd4);
    check("extr_wr_low", 32'(d_wr), 32'd0);
    check("extr_eaddr",  32'(bus.ext_address_o), 32'h2000);
    check("extr_pulses", 32'(d_pulse), 32'd1);

    // External write: cpu_data_o keeps the previous read value.
    bus.ext_data_i = 8'hEE;
    access(16'h8000, 8'h77, 1'b1);
    check("extw_lat",    32'(lat), 32'd5);
    check("extw_data",   32'(rdata), 32'h3C);
    check("extw_wr_low", 32'(d_wr), 32'd4);
    check("extw_oe",     32'(d_oe), 32'd4);
    check("extw_rd_low", 32'(d_rd), 32'd0);
    check("extw_edata",  32'(bus.ext_data_o), 32'h77);
    check("extw_eaddr",  32'(bus.ext_address_o), 32'h8000);
    check("extw_oe_off", 32'(bus.ext_data_oe_o), 32'h0);

    // Request held through RESPOND and COOLDOWN, dropped on the IDLE cycle.
    p0 = pulse_cnt;
    @(posedge clock_i); #1;
    bus.cpu_address_i = 16'h0805; bus.cpu_address_valid_i = 1'b1;
    repeat (4) @(posedge clock_i); #1;
    bus.cpu_address_valid_i = 1'b0;
    repeat (8) @(posedge clock_i);
    @(negedge clock_i);
    check("hold_one", 32'(pulse_cnt - p0), 32'd1);
    check("hold_data", 32'(bus.cpu_data_o), 32'hA5);
    // Held across two IDLE visits: accepted exactly twice.
    p0 = pulse_cnt;
    @(posedge clock_i); #1;
    bus.cpu_address_valid_i = 1'b1;
    repeat (8) @(posedge clock_i); #1;
    bus.cpu_address_valid_i = 1'b0;
    repeat (8) @(posedge clock_i);
    @(negedge clock_i);
    check("hold_two", 32'(pulse_cnt - p0), 32'd2);

    // Reset during the 2nd strobe cycle of an external read.
    bus.ext_data_i = 8'h3C;
    p0 = pulse_cnt;
    @(posedge clock_i); #1;
    bus.cpu_address_i = 16'h2000; bus.cpu_address_valid_i = 1'b1;
    repeat (2) @(posedge clock_i); #1;
    reset_n_i = 1'b0;
    @(negedge clock_i);
    check("mid_strobe_on", 32'(bus.ext_read_n_o), 32'h0);
    @(negedge clock_i);
    check("mid_rd_n",   32'(bus.ext_read_n_o), 32'h1);
    check("mid_valid",  32'(bus.cpu_data_valid_o), 32'h0);
    check("mid_eaddr",  32'(bus.ext_address_o), 32'h0);
    check("mid_data",   32'(bus.cpu_data_o), 32'h0);
    @(posedge clock_i); #1;
    reset_n_i = 1'b1; bus.cpu_address_valid_i = 1'b0;
    repeat (8) @(posedge clock_i);
    @(negedge clock_i);
    check("mid_nopulse", 32'(pulse_cnt - p0), 32'd0);
    check("mid_rd_idle", 32'(bus.ext_read_n_o), 32'h1);
    // RAM survives reset and the bridge is back in IDLE.
    access(16'h0005, 8'h00, 1'b0);
    check("post_lat",  32'(lat), 32'd2);
    check("post_data", 32'(rdata), 32'hA5);

    // Open-bus range read.
    access(16'h0010, 8'h5A, 1'b1);
    bus.ext_data_i = 8'h96;
    access(16'h4100, 8'h00, 1'b0);
`ifdef CPU_BUS_OPEN_BUS_EN
    check("ob_lat",    32'(lat), 32'd1);
    check("ob_data",   32'(rdata), 32'h5A);
    check("ob_nostrb", 32'(d_rd), 32'd0);
`else
    check("ob_lat",    32'(lat), 32'd5);
    check("ob_data",   32'(rdata), 32'h96);
    check("ob_rd_low", 32'(d_rd), 32'd4);
`endif
    check("ob_pulses", 32'(d_pulse), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
